// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: captures decoded instruction fields for the execute stage,
// with flush (bubble) over freeze (hold) priority and saturating stall/bubble counters.
module id_exe_stage_reg #(
    parameter int unsigned ADDRESS_LEN         = 32,
    parameter int unsigned REGISTER_LEN        = 32,
    parameter int unsigned EXECUTE_COMMAND_LEN = 4,
    parameter int unsigned SHIFT_OPERAND_LEN   = 12,
    parameter int unsigned REGFILE_ADDRESS_LEN = 4,
    parameter int unsigned CNT_LEN             = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           freeze,
    input  logic                           valid_in,
    input  logic [ADDRESS_LEN-1:0]         PC_in,
    input  logic                           mem_read_in,
    input  logic                           mem_write_in,
    input  logic                           wb_enable_in,
    input  logic                           branch_taken_in,
    input  logic                           status_write_enable_in,
    input  logic [EXECUTE_COMMAND_LEN-1:0] execute_command_in,
    input  logic [REGISTER_LEN-1:0]        reg_val1_in,
    input  logic [REGISTER_LEN-1:0]        reg_val2_in,
    input  logic                           immediate_in,
    input  logic [23:0]                    signed_immediate_in,
    input  logic [SHIFT_OPERAND_LEN-1:0]   shift_operand_in,
    input  logic [REGFILE_ADDRESS_LEN-1:0] dest_reg_in,
    input  logic [REGFILE_ADDRESS_LEN-1:0] src1_in,
    input  logic [REGFILE_ADDRESS_LEN-1:0] src2_in,
    input  logic [3:0]                     status_in,
    output logic                           valid_out,
    output logic [ADDRESS_LEN-1:0]         PC_out,
    output logic                           mem_read_out,
    output logic                           mem_write_out,
    output logic                           wb_enable_out,
    output logic                           branch_taken_out,
    output logic                           status_write_enable_out,
    output logic [EXECUTE_COMMAND_LEN-1:0] execute_command_out,
    output logic [REGISTER_LEN-1:0]        reg_val1_out,
    output logic [REGISTER_LEN-1:0]        reg_val2_out,
    output logic                           immediate_out,
    output logic [23:0]                    signed_immediate_out,
    output logic [SHIFT_OPERAND_LEN-1:0]   shift_operand_out,
    output logic [REGFILE_ADDRESS_LEN-1:0] dest_reg_out,
    output logic [REGFILE_ADDRESS_LEN-1:0] src1_out,
    output logic [REGFILE_ADDRESS_LEN-1:0] src2_out,
    output logic [3:0]                     status_out,
    output logic [CNT_LEN-1:0]             stall_count,
    output logic [CNT_LEN-1:0]             bubble_count
);

    typedef struct packed {
        logic                           valid;
        logic [ADDRESS_LEN-1:0]         pc;
        logic                           mem_read;
        logic                           mem_write;
        logic                           wb_enable;
        logic                           branch_taken;
        logic                           status_we;
        logic [EXECUTE_COMMAND_LEN-1:0] exe_cmd;
        logic [REGISTER_LEN-1:0]        reg_val1;
        logic [REGISTER_LEN-1:0]        reg_val2;
        logic                           imm;
        logic [23:0]                    signed_imm;
        logic [SHIFT_OPERAND_LEN-1:0]   shift_operand;
        logic [REGFILE_ADDRESS_LEN-1:0] dest_reg;
        logic [REGFILE_ADDRESS_LEN-1:0] src1;
        logic [REGFILE_ADDRESS_LEN-1:0] src2;
        logic [3:0]                     status;
    } stage_t;

    stage_t stage_in, stage_d, stage_q;
    logic [CNT_LEN-1:0] stall_d, stall_q, bubble_d, bubble_q;
    logic stall_inc, bubble_inc;

    assign stage_in = '{
        valid:         valid_in,
        pc:            PC_in,
        mem_read:      mem_read_in,
        mem_write:     mem_write_in,
        wb_enable:     wb_enable_in,
        branch_taken:  branch_taken_in,
        status_we:     status_write_enable_in,
        exe_cmd:       execute_command_in,
        reg_val1:      reg_val1_in,
        reg_val2:      reg_val2_in,
        imm:           immediate_in,
        signed_imm:    signed_immediate_in,
        shift_operand: shift_operand_in,
        dest_reg:      dest_reg_in,
        src1:          src1_in,
        src2:          src2_in,
        status:        status_in
    };

    // Flush beats freeze so a taken branch kills a stalled younger instruction.
    always_comb begin
        stage_d    = stage_q;
        stall_inc  = 1'b0;
        bubble_inc = 1'b0;
        if (flush) begin
            stage_d    = '0;
            bubble_inc = 1'b1;
        end else if (freeze) begin
            stall_inc = 1'b1;
        end else begin
            stage_d    = stage_in;
            bubble_inc = ~valid_in;
        end
        stall_d  = (stall_inc && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
        bubble_d = (bubble_inc && !(&bubble_q)) ? bubble_q + 1'b1 : bubble_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q  <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stage_q  <= stage_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign valid_out               = stage_q.valid;
    assign PC_out                  = stage_q.pc;
    assign mem_read_out            = stage_q.mem_read;
    assign mem_write_out           = stage_q.mem_write;
    assign wb_enable_out           = stage_q.wb_enable;
    assign branch_taken_out        = stage_q.branch_taken;
    assign status_write_enable_out = stage_q.status_we;
    assign execute_command_out     = stage_q.exe_cmd;
    assign reg_val1_out            = stage_q.reg_val1;
    assign reg_val2_out            = stage_q.reg_val2;
    assign immediate_out           = stage_q.imm;
    assign signed_immediate_out    = stage_q.signed_imm;
    assign shift_operand_out       = stage_q.shift_operand;
    assign dest_reg_out            = stage_q.dest_reg;
    assign src1_out                = stage_q.src1;
    assign src2_out                = stage_q.src2;
    assign status_out              = stage_q.status;
    assign stall_count             = stall_q;
    assign bubble_count            = bubble_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg: a default instance plus a CNT_LEN=4 instance
// sharing the same stimulus for counter saturation.
module tb_id_exe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush, freeze, valid_in;
    logic [31:0] PC_in, reg_val1_in, reg_val2_in;
    logic        mem_read_in, mem_write_in, wb_enable_in, branch_taken_in, status_we_in;
    logic [3:0]  execute_command_in, dest_reg_in, src1_in, src2_in, status_in;
    logic        immediate_in;
    logic [23:0] signed_immediate_in;
    logic [11:0] shift_operand_in;

    logic        valid_out, mem_read_out, mem_write_out, wb_enable_out, branch_taken_out;
    logic        status_we_out, immediate_out;
    logic [31:0] PC_out, reg_val1_out, reg_val2_out;
    logic [3:0]  execute_command_out, dest_reg_out, src1_out, src2_out, status_out;
    logic [23:0] signed_immediate_out;
    logic [11:0] shift_operand_out;
    logic [15:0] stall_count, bubble_count;

    logic        s_valid_out, s_mem_read_out, s_mem_write_out, s_wb_enable_out;
    logic        s_branch_taken_out, s_status_we_out, s_immediate_out;
    logic [31:0] s_PC_out, s_reg_val1_out, s_reg_val2_out;
    logic [3:0]  s_execute_command_out, s_dest_reg_out, s_src1_out, s_src2_out, s_status_out;
    logic [23:0] s_signed_immediate_out;
    logic [11:0] s_shift_operand_out;
    logic [3:0]  s_stall_count, s_bubble_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
        .PC_in(PC_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .wb_enable_in(wb_enable_in), .branch_taken_in(branch_taken_in),
        .status_write_enable_in(status_we_in), .execute_command_in(execute_command_in),
        .reg_val1_in(reg_val1_in), .reg_val2_in(reg_val2_in), .immediate_in(immediate_in),
        .signed_immediate_in(signed_immediate_in), .shift_operand_in(shift_operand_in),
        .dest_reg_in(dest_reg_in), .src1_in(src1_in), .src2_in(src2_in),
        .status_in(status_in), .valid_out(valid_out), .PC_out(PC_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .wb_enable_out(wb_enable_out), .branch_taken_out(branch_taken_out),
        .status_write_enable_out(status_we_out), .execute_command_out(execute_command_out),
        .reg_val1_out(reg_val1_out), .reg_val2_out(reg_val2_out),
        .immediate_out(immediate_out), .signed_immediate_out(signed_immediate_out),
        .shift_operand_out(shift_operand_out), .dest_reg_out(dest_reg_out),
        .src1_out(src1_out), .src2_out(src2_out), .status_out(status_out),
        .stall_count(stall_count), .bubble_count(bubble_count)
    );

    id_exe_stage_reg #(.CNT_LEN(4)) dut_small (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
        .PC_in(PC_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .wb_enable_in(wb_enable_in), .branch_taken_in(branch_taken_in),
        .status_write_enable_in(status_we_in), .execute_command_in(execute_command_in),
        .reg_val1_in(reg_val1_in), .reg_val2_in(reg_val2_in), .immediate_in(immediate_in),
        .signed_immediate_in(signed_immediate_in), .shift_operand_in(shift_operand_in),
        .dest_reg_in(dest_reg_in), .src1_in(src1_in), .src2_in(src2_in),
        .status_in(status_in), .valid_out(s_valid_out), .PC_out(s_PC_out),
        .mem_read_out(s_mem_read_out), .mem_write_out(s_mem_write_out),
        .wb_enable_out(s_wb_enable_out), .branch_taken_out(s_branch_taken_out),
        .status_write_enable_out(s_status_we_out),
        .execute_command_out(s_execute_command_out),
        .reg_val1_out(s_reg_val1_out), .reg_val2_out(s_reg_val2_out),
        .immediate_out(s_immediate_out), .signed_immediate_out(s_signed_immediate_out),
        .shift_operand_out(s_shift_operand_out), .dest_reg_out(s_dest_reg_out),
        .src1_out(s_src1_out), .src2_out(s_src2_out), .status_out(s_status_out),
        .stall_count(s_stall_count), .bubble_count(s_bubble_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        {mem_read_in, mem_write_in, wb_enable_in, branch_taken_in, status_we_in} = '0;
        {PC_in, reg_val1_in, reg_val2_in} = '0;
        {execute_command_in, dest_reg_in, src1_in, src2_in, status_in} = '0;
        immediate_in = 1'b0; signed_immediate_in = '0; shift_operand_in = '0;
        valid_in = 1'b0;
    endtask

    // OR of every data/control output, for "all outputs zero" checks.
    function automatic logic [31:0] any_out();
        return PC_out | reg_val1_out | reg_val2_out | {8'h0, signed_immediate_out}
             | {20'h0, shift_operand_out}
             | {16'h0, execute_command_out, dest_reg_out, src1_out, src2_out}
             | {28'h0, status_out}
             | {25'h0, mem_read_out, mem_write_out, wb_enable_out, branch_taken_out,
                status_we_out, immediate_out, valid_out};
    endfunction

    initial begin
        // Reset with every input nonzero, flush and freeze included.
        rst = 1; flush = 1; freeze = 1; valid_in = 1;
        PC_in = 32'hFFFF_FFFC; reg_val1_in = 32'h1234_5678; reg_val2_in = 32'h9ABC_DEF0;
        {mem_read_in, mem_write_in, wb_enable_in, branch_taken_in, status_we_in} = '1;
        execute_command_in = 4'hF; dest_reg_in = 4'hE; src1_in = 4'hD; src2_in = 4'hC;
        status_in = 4'hB; immediate_in = 1; signed_immediate_in = 24'hABCDEF;
        shift_operand_in = 12'hFFF;
        step();
        chk("reset_outputs", any_out(), 0);
        chk("reset_valid", valid_out, 0);
        chk("reset_stall", stall_count, 0);
        chk("reset_bubble", bubble_count, 0);

        // First load after reset.
        rst = 0; flush = 0; freeze = 0; zero_inputs();
        PC_in = 32'h4; execute_command_in = 4'b1001; wb_enable_in = 1; valid_in = 1;
        step();
        chk("load_pc", PC_out, 32'h4);
        chk("load_exe_cmd", execute_command_out, 4'b1001);
        chk("load_wb", wb_enable_out, 1);
        chk("load_valid", valid_out, 1);

        // Freeze hold for 3 cycles while inputs change.
        PC_in = 32'h10; reg_val1_in = 32'hDEAD_BEEF; status_in = 4'b0010;
        step();
        chk("pre_freeze_pc", PC_out, 32'h10);
        freeze = 1; PC_in = 32'h14; reg_val1_in = 32'h0; status_in = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("freeze_pc", PC_out, 32'h10);
            chk("freeze_rv1", reg_val1_out, 32'hDEAD_BEEF);
            chk("freeze_status", status_out, 4'b0010);
        end
        chk("freeze_stall3", stall_count, 3);
        chk("freeze_bubble0", bubble_count, 0);
        freeze = 0;
        step();
        chk("release_pc", PC_out, 32'h14);
        chk("release_rv1", reg_val1_out, 32'h0);
        chk("release_stall", stall_count, 3);

        // Flush together with freeze; X on data inputs must not leak.
        mem_write_in = 1; PC_in = 32'h20;
        step();
        chk("pre_flush_memw", mem_write_out, 1);
        chk("pre_flush_valid", valid_out, 1);
        flush = 1; freeze = 1; PC_in = 'x; reg_val2_in = 'x;
        step();
        chk("flush_outputs", any_out(), 0);
        chk("flush_valid", valid_out, 0);
        chk("flush_bubble", bubble_count, 1);
        chk("flush_stall", stall_count, 3);

        // Input bubbles for 2 cycles.
        flush = 0; freeze = 0; zero_inputs(); PC_in = 32'h24;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bubble_valid", valid_out, 0);
        end
        chk("bubble_count3", bubble_count, 3);
        chk("bubble_pc", PC_out, 32'h24);

        // Reset mid-stall.
        rst = 1; step(); rst = 0;
        PC_in = 32'h30; valid_in = 1; src1_in = 4'h5;
        step();
        chk("mid_load_pc", PC_out, 32'h30);
        freeze = 1;
        for (int i = 0; i < 5; i++) step();
        chk("mid_stall5", stall_count, 5);
        rst = 1;
        step();
        chk("mid_rst_stall", stall_count, 0);
        chk("mid_rst_outputs", any_out(), 0);
        rst = 0;
        step();
        chk("post_rst_outputs", any_out(), 0);
        chk("post_rst_stall", stall_count, 1);

        // Saturation on the CNT_LEN=4 instance.
        rst = 1; step(); rst = 0;
        chk("sat_reset", s_stall_count, 0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk("sat_stall14", s_stall_count, 14);
            if (i == 15) chk("sat_stall15", s_stall_count, 15);
        end
        chk("sat_stall_hold", s_stall_count, 15);
        chk("sat_bubble", s_bubble_count, 0);
        chk("wide_stall20", stall_count, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
